// File: rtl/cpu_pipeline_ctrl.sv
// rtl/cpu_pipeline_ctrl.sv - fetch/decode/execute sequencing controller
//
// Purpose: steps one instruction at a time through FETCH, DECODE and EXECUTE,
// tracks the program counter and retired-instruction count, and parks in
// HALTED at instruction boundaries while halt is held.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   halt                  stop at the next instruction boundary
//   mem_req/mem_addr      fetch request and word-aligned address
//   mem_ready/mem_rdata   fetch completion and instruction word
//   dec_enable/dec_IR     one-cycle decoder strobe and instruction word
//   exec_start            one-cycle pulse on the first EXECUTE cycle
//   exec_done             execute finished (honoured only in EXECUTE)
//   branch_taken/_target  redirect qualifiers sampled with exec_done
//   pc/pc_plus8           address in flight and its R15-visible value
//   instr_count           retired-instruction counter (wraps)
//   halted                high while in HALTED

module cpu_pipeline_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        halt,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        dec_enable,
  output logic [31:0] dec_IR,
  output logic        exec_start,
  input  logic        exec_done,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus8,
  output logic [31:0] instr_count,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_HALTED  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] instr_count_q, instr_count_d;
  logic        exec_first_q, exec_first_d;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_VECTOR;
      ir_q          <= 32'h0;
      instr_count_q <= 32'h0;
      exec_first_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      ir_q          <= ir_d;
      instr_count_q <= instr_count_d;
      exec_first_q  <= exec_first_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ir_d          = ir_q;
    instr_count_d = instr_count_q;
    // EXECUTE is only ever entered from DECODE, so being in DECODE now
    // marks the next cycle as the first EXECUTE cycle.
    exec_first_d  = (state_q == S_DECODE);

    case (state_q)
      S_IDLE: begin
        state_d = halt ? S_HALTED : S_FETCH;
      end
      S_FETCH: begin
        if (mem_ready) begin
          ir_d    = mem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        if (exec_done) begin
          instr_count_d = instr_count_q + 32'd1;
          // Branch targets are forced word aligned; low bits are discarded.
          pc_d          = branch_taken ? (branch_target & 32'hFFFF_FFFC)
                                       : (pc_q + 32'd4);
          state_d       = halt ? S_HALTED : S_FETCH;
        end
      end
      S_HALTED: begin
        if (!halt) state_d = S_FETCH;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decoded from the current state only
  always_comb begin
    mem_req     = (state_q == S_FETCH);
    dec_enable  = (state_q == S_DECODE);
    exec_start  = (state_q == S_EXECUTE) && exec_first_q;
    halted      = (state_q == S_HALTED);
    mem_addr    = pc_q;
    dec_IR      = ir_q;
    pc          = pc_q;
    pc_plus8    = pc_q + 32'd8;
    instr_count = instr_count_q;
  end

endmodule

// File: tb/tb_cpu_pipeline_ctrl.sv
// tb/tb_cpu_pipeline_ctrl.sv - self-checking bench for cpu_pipeline_ctrl

module tb_cpu_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        reset, halt, mem_ready, exec_done, branch_taken;
  logic [31:0] mem_rdata, branch_target;
  logic        mem_req, dec_enable, exec_start, halted;
  logic [31:0] mem_addr, dec_IR, pc, pc_plus8, instr_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cpu_pipeline_ctrl #(.RESET_VECTOR(32'h0000_0000)) dut (
    .clk          (clk),
    .reset        (reset),
    .halt         (halt),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ready    (mem_ready),
    .mem_rdata    (mem_rdata),
    .dec_enable   (dec_enable),
    .dec_IR       (dec_IR),
    .exec_start   (exec_start),
    .exec_done    (exec_done),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .pc           (pc),
    .pc_plus8     (pc_plus8),
    .instr_count  (instr_count),
    .halted       (halted)
  );

  typedef struct {
    logic        rst;
    logic        hlt;
    logic        rdy;
    logic [31:0] rdata;
    logic        done;
    logic        bt;
    logic [31:0] tgt;
    logic        e_req;
    logic        e_dec;
    logic        e_start;
    logic        e_halted;
    logic [31:0] e_ir;
    logic [31:0] e_pc;
    logic [31:0] e_cnt;
  } vec_t;

  localparam int NV = 26;
  vec_t v [NV];

  task automatic check(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row=%0d actual=%h expected=%h", name, row, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t r);
    reset         = r.rst;
    halt          = r.hlt;
    mem_ready     = r.rdy;
    mem_rdata     = r.rdata;
    exec_done     = r.done;
    branch_taken  = r.bt;
    branch_target = r.tgt;
  endtask

  initial begin
    int n;
    //        rst hlt rdy rdata         done bt tgt            req dec st hlt ir            pc            cnt
    v[0]  = '{1, 0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 0, 0, 32'h0,         32'h0,         32'd0};
    v[1]  = '{0, 0, 1, 32'hE3A0_0001, 1, 0, 32'h0,         1, 0, 0, 0, 32'h0,         32'h0,         32'd0};
    v[2]  = '{0, 0, 1, 32'hE3A0_0001, 1, 0, 32'h0,         0, 1, 0, 0, 32'hE3A0_0001, 32'h0,         32'd0};
    v[3]  = '{0, 0, 1, 32'h1111_1111, 1, 0, 32'h0,         0, 0, 1, 0, 32'hE3A0_0001, 32'h0,         32'd0};
    v[4]  = '{0, 0, 1, 32'h2222_2222, 1, 0, 32'h0,         1, 0, 0, 0, 32'hE3A0_0001, 32'h4,         32'd1};
    v[5]  = '{0, 0, 1, 32'h2222_2222, 1, 0, 32'h0,         0, 1, 0, 0, 32'h2222_2222, 32'h4,         32'd1};
    v[6]  = '{0, 0, 1, 32'h0,         0, 0, 32'h0,         0, 0, 1, 0, 32'h2222_2222, 32'h4,         32'd1};
    v[7]  = '{0, 0, 1, 32'h0,         1, 1, 32'h0800_0103, 1, 0, 0, 0, 32'h2222_2222, 32'h0800_0100, 32'd2};
    v[8]  = '{0, 0, 1, 32'h3333_3333, 0, 0, 32'h0,         0, 1, 0, 0, 32'h3333_3333, 32'h0800_0100, 32'd2};
    v[9]  = '{0, 1, 1, 32'h0,         0, 0, 32'h0,         0, 0, 1, 0, 32'h3333_3333, 32'h0800_0100, 32'd2};
    v[10] = '{0, 1, 1, 32'h0,         0, 0, 32'h0,         0, 0, 0, 0, 32'h3333_3333, 32'h0800_0100, 32'd2};
    v[11] = '{0, 1, 1, 32'h0,         1, 0, 32'h0,         0, 0, 0, 1, 32'h3333_3333, 32'h0800_0104, 32'd3};
    v[12] = '{0, 1, 1, 32'h4444_4444, 1, 1, 32'h0,         0, 0, 0, 1, 32'h3333_3333, 32'h0800_0104, 32'd3};
    v[13] = '{0, 0, 0, 32'h0,         0, 0, 32'h0,         1, 0, 0, 0, 32'h3333_3333, 32'h0800_0104, 32'd3};
    v[14] = '{0, 0, 0, 32'h0,         0, 0, 32'h0,         1, 0, 0, 0, 32'h3333_3333, 32'h0800_0104, 32'd3};
    v[15] = '{0, 0, 0, 32'h0,         1, 0, 32'h0,         1, 0, 0, 0, 32'h3333_3333, 32'h0800_0104, 32'd3};
    v[16] = '{0, 1, 0, 32'h0,         0, 0, 32'h0,         1, 0, 0, 0, 32'h3333_3333, 32'h0800_0104, 32'd3};
    v[17] = '{0, 0, 1, 32'hE3A0_0001, 0, 0, 32'h0,         0, 1, 0, 0, 32'hE3A0_0001, 32'h0800_0104, 32'd3};
    v[18] = '{0, 0, 1, 32'h0,         0, 0, 32'h0,         0, 0, 1, 0, 32'hE3A0_0001, 32'h0800_0104, 32'd3};
    v[19] = '{0, 0, 0, 32'h0,         1, 0, 32'h0,         1, 0, 0, 0, 32'hE3A0_0001, 32'h0800_0108, 32'd4};
    v[20] = '{0, 0, 0, 32'h0,         0, 0, 32'h0,         1, 0, 0, 0, 32'hE3A0_0001, 32'h0800_0108, 32'd4};
    v[21] = '{1, 0, 1, 32'hDEAD_BEEF, 1, 0, 32'h0,         0, 0, 0, 0, 32'h0,         32'h0,         32'd0};
    v[22] = '{0, 0, 1, 32'hDEAD_BEEF, 0, 0, 32'h0,         1, 0, 0, 0, 32'h0,         32'h0,         32'd0};
    v[23] = '{1, 0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 0, 0, 32'h0,         32'h0,         32'd0};
    v[24] = '{0, 1, 0, 32'h0,         0, 0, 32'h0,         0, 0, 0, 1, 32'h0,         32'h0,         32'd0};
    v[25] = '{0, 0, 0, 32'h0,         0, 0, 32'h0,         1, 0, 0, 0, 32'h0,         32'h0,         32'd0};

    reset = 1'b1; halt = 1'b0; mem_ready = 1'b0; mem_rdata = 32'h0;
    exec_done = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    step();

    for (int i = 0; i < NV; i++) begin
      drive(v[i]);
      step();
      check("mem_req",     i, {31'b0, mem_req},    {31'b0, v[i].e_req});
      check("mem_addr",    i, mem_addr,            v[i].e_pc);
      check("dec_enable",  i, {31'b0, dec_enable}, {31'b0, v[i].e_dec});
      check("exec_start",  i, {31'b0, exec_start}, {31'b0, v[i].e_start});
      check("halted",      i, {31'b0, halted},     {31'b0, v[i].e_halted});
      check("dec_IR",      i, dec_IR,              v[i].e_ir);
      check("pc",          i, pc,                  v[i].e_pc);
      check("pc_plus8",    i, pc_plus8,            v[i].e_pc + 32'd8);
      check("instr_count", i, instr_count,         v[i].e_cnt);
      check("one_hot_strobes", i,
            {30'b0, 2'(mem_req + dec_enable + exec_start) > 2'd1 ? 2'd1 : 2'd0}, 32'd0);
    end

    // Counter wrap: preload all-ones while stalled in FETCH at pc 0.
    reset = 1'b0; halt = 1'b0; mem_ready = 1'b0; exec_done = 1'b0;
    branch_taken = 1'b0;
    force dut.instr_count_q = 32'hFFFF_FFFF;
    step();
    release dut.instr_count_q;
    step();
    check("wrap_preload", 100, instr_count, 32'hFFFF_FFFF);
    check("wrap_stall_req", 100, {31'b0, mem_req}, 32'd1);

    mem_ready = 1'b1; mem_rdata = 32'hCAFE_F00D;
    step();
    check("wrap_dec_IR", 101, dec_IR, 32'hCAFE_F00D);
    mem_ready = 1'b0;
    n = 0;
    while (!exec_start && n < 8) begin
      step();
      n++;
    end
    check("wrap_exec_start_seen", 102, {31'b0, exec_start}, 32'd1);

    exec_done = 1'b1;
    step();
    exec_done = 1'b0;
    check("wrap_count", 103, instr_count, 32'h0);
    check("wrap_pc", 103, pc, 32'h4);
    check("wrap_next_fetch", 103, {31'b0, mem_req}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
